liteeth_1rw1r_sram_model: RTL and testbench
===========================================

Name: liteeth_1rw1r_sram_model

Overview:
- Parametrised synthesizable/behavioural 1RW+1R SRAM model for the liteeth SRAM macros.
- Replaces fixed-geometry black boxes in RTL simulation and FPGA builds.
- Adds:
  - configurable width, depth and write-mask granularity
  - selectable read latency
  - defined read-during-write collision semantics
  - read-valid strobes
  - sticky out-of-range error flag
- Sits between the liteeth MAC buffers and the memory; pin-compatible naming with the macro family.

Parameters:
- BITS, 32, data word width; must be a multiple of MASK_GRAN.
- WORD_DEPTH, 384, number of words; need not be a power of two.
- ADDR_WIDTH, 9, address width; must be ≥ $clog2(WORD_DEPTH).
- MASK_GRAN, 8, bits per write-mask lane; WMASK_W = BITS/MASK_GRAN.
- READ_LATENCY, 1, 1 = registered array read; 2 = additional output register.
- RDW_MODE, 0, r0 read vs rw0 write to same address in same cycle: 0 = old data, 1 = new (merged) data.

Ports:
- clk  in  1  single clock for both ports
- rst_n  in  1  asynchronous, active-low reset
- r0_ce_in  in  1  read-port enable
- r0_addr_in  in  ADDR_WIDTH  read-port address
- r0_rd_out  out  BITS  read-port data
- r0_rd_valid_out  out  1  r0_rd_out valid strobe
- rw0_ce_in  in  1  rw-port enable
- rw0_we_in  in  1  1 = write, 0 = read (when rw0_ce_in=1)
- rw0_addr_in  in  ADDR_WIDTH  rw-port address
- rw0_wd_in  in  BITS  write data
- rw0_wmask_in  in  WMASK_W  per-lane write enable; lane i covers bits [i*MASK_GRAN +: MASK_GRAN]
- rw0_rd_out  out  BITS  rw-port read data
- rw0_rd_valid_out  out  1  rw0_rd_out valid strobe
- collision_out  out  1  pulse aligned with r0_rd_valid_out when that read collided with an rw0 write
- oob_err_out  out  1  sticky: any enabled access with address ≥ WORD_DEPTH

Behaviour:
- Reset (rst_n low, asynchronous):
  - all outputs 0; pipeline valid/data registers cleared; in-flight reads dropped
  - array contents NOT reset and retained
  - writes suppressed while rst_n low
- Write (rw0_ce_in & rw0_we_in, in range): at the clock edge, only lanes with wmask=1 are updated; other lanes keep old contents.
- rw0 on a write cycle: no read is issued; rw0_rd_out holds its previous value and rw0_rd_valid_out stays 0.
- Reads:
  - enabled when ce=1 (r0), or when ce=1 & we=0 (rw0)
  - data and valid appear READ_LATENCY cycles after the request edge
  - valid is a 1-cycle pulse per request
  - back-to-back reads are accepted every cycle (fully pipelined, no stalls)
- Output hold: data outputs hold their last value between reads; they change only on a valid-producing cycle.
- Collision (r0 read and rw0 write, same in-range address, same cycle):
  - RDW_MODE=0: r0 returns the pre-write word
  - RDW_MODE=1: r0 returns the merged word (masked lanes = wd, others = old)
  - collision_out pulses together with that r0_rd_valid_out
  - both modes: the array ends with the merged word
- rw0 with wmask=0: valid write cycle, array unchanged; collision_out is still flagged if r0 hits the same address.
- Out-of-range address (≥ WORD_DEPTH, relevant when WORD_DEPTH < 2^ADDR_WIDTH):
  - write ignored
  - read returns all-zero data with valid asserted
  - oob_err_out set to 1 at the next edge; stays 1 until reset
- Simultaneous reads of the same address on both ports: both return the same stored word; no collision is flagged.
- Mid-operation reset: if reset asserts with reads in flight, no valid is emitted for them after deassertion.
- Parameter legality checked at elaboration (fatal):
  - BITS % MASK_GRAN == 0
  - 2^ADDR_WIDTH ≥ WORD_DEPTH
  - READ_LATENCY ∈ {1,2}
  - RDW_MODE ∈ {0,1}

Decomposition:
- Package liteeth_sram_pkg:
  - RDW_OLD=0, RDW_NEW=1 localparams
  - function wmask_width(bits, gran)
  - function merge_word(old, wd, mask, gran) returning the lane-merged word
- Sub-module liteeth_sram_rd_pipe (params BITS, READ_LATENCY):
  - carries data + valid (+ collision flag for r0) through 0 or 1 extra register stages with async reset
  - instantiated once per read port

Test Plan:
- Write 0xDEADBEEF to addr 5 with mask 4'hF, then r0 read addr 5 (READ_LATENCY=1) → r0_rd_out=0xDEADBEEF, r0_rd_valid_out high exactly 1 cycle after the read edge.
- Fill addr 7 with 0x11223344, write 0xAABBCCDD with mask 4'b0101, rw0 read addr 7 → 0x11BB33DD.
- Addr 9 holds 0x0; same cycle: rw0 writes 0x12345678 (mask F) and r0 reads addr 9:
  - RDW_MODE=0 → r0_rd_out=0x00000000, collision_out=1
  - RDW_MODE=1 → r0_rd_out=0x12345678, collision_out=1
  - following read → 0x12345678
- READ_LATENCY=2: reads to addrs 1,2,3 on consecutive cycles → three valid pulses on cycles +2,+3,+4 with matching data in order.
- WORD_DEPTH=384: write 0xFFFFFFFF to addr 400, then read addr 400 → r0_rd_out=0, valid=1, oob_err_out=1 and remains 1; word at addr 400-256=144 is unchanged.
- Issue a read (READ_LATENCY=2), assert rst_n low one cycle later for 2 cycles:
  - outputs go 0 immediately
  - no valid after release
  - earlier-written addr 5 still reads 0xDEADBEEF

Source files
------------

// File: rtl/liteeth_sram_pkg.sv
// Shared constants and helpers for the liteeth 1RW+1R SRAM model.
package liteeth_sram_pkg;

    localparam int unsigned RDW_OLD = 0;
    localparam int unsigned RDW_NEW = 1;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int unsigned SRAM_MAX_BITS = 1024;
    localparam int unsigned SRAM_IDX_W    = 10;

    function automatic int unsigned wmask_width(input int unsigned bits, input int unsigned gran);
        return bits / gran;
    endfunction

    function automatic logic [SRAM_MAX_BITS-1:0] merge_word(
        input logic [SRAM_MAX_BITS-1:0] old_word,
        input logic [SRAM_MAX_BITS-1:0] wd,
        input logic [SRAM_MAX_BITS-1:0] mask,
        input int unsigned              gran
    );
        logic [SRAM_MAX_BITS-1:0] res;
        res = old_word;
        for (int unsigned b = 0; b < SRAM_MAX_BITS; b++) begin
            if (mask[SRAM_IDX_W'(b / gran)]) begin
                res[SRAM_IDX_W'(b)] = wd[SRAM_IDX_W'(b)];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/liteeth_sram_rd_pipe.sv
// Read-return pipeline: registered array read plus an optional output register.
module liteeth_sram_rd_pipe
    import liteeth_sram_pkg::*;
#(
    parameter int unsigned BITS         = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_in,
    input  logic [BITS-1:0] data_in,
    output logic            valid_out,
    output logic [BITS-1:0] data_out
);

    logic [BITS-1:0] s1_data;
    logic            s1_valid;

    // Data registers load only on a request so outputs hold between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= req_in;
            if (req_in) begin
                s1_data <= data_in;
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_out_reg
        logic [BITS-1:0] s2_data;
        logic            s2_valid;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_data  <= '0;
                s2_valid <= 1'b0;
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s1_data;
                end
            end
        end

        assign valid_out = s2_valid;
        assign data_out  = s2_data;
    end else begin : g_no_out_reg
        assign valid_out = s1_valid;
        assign data_out  = s1_data;
    end

endmodule

// File: rtl/liteeth_1rw1r_sram_model.sv
// Parametrised 1RW+1R SRAM model with lane write masks, selectable read latency,
// defined read-during-write behaviour and a sticky out-of-range error flag.
module liteeth_1rw1r_sram_model
    import liteeth_sram_pkg::*;
#(
    parameter int unsigned BITS         = 32,
    parameter int unsigned WORD_DEPTH   = 384,
    parameter int unsigned ADDR_WIDTH   = 9,
    parameter int unsigned MASK_GRAN    = 8,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned RDW_MODE     = 0,
    localparam int unsigned WMASK_W     = wmask_width(BITS, MASK_GRAN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  r0_ce_in,
    input  logic [ADDR_WIDTH-1:0] r0_addr_in,
    output logic [BITS-1:0]       r0_rd_out,
    output logic                  r0_rd_valid_out,
    input  logic                  rw0_ce_in,
    input  logic                  rw0_we_in,
    input  logic [ADDR_WIDTH-1:0] rw0_addr_in,
    input  logic [BITS-1:0]       rw0_wd_in,
    input  logic [WMASK_W-1:0]    rw0_wmask_in,
    output logic [BITS-1:0]       rw0_rd_out,
    output logic                  rw0_rd_valid_out,
    output logic                  collision_out,
    output logic                  oob_err_out
);

    if (BITS % MASK_GRAN != 0) begin : g_bad_gran
        $fatal(1, "BITS must be a multiple of MASK_GRAN");
    end
    if (BITS > SRAM_MAX_BITS) begin : g_bad_bits
        $fatal(1, "BITS exceeds supported maximum word width");
    end
    if ((ADDR_WIDTH < 32) && ((64'd1 << ADDR_WIDTH) < 64'(WORD_DEPTH))) begin : g_bad_addr
        $fatal(1, "ADDR_WIDTH too small for WORD_DEPTH");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
        $fatal(1, "READ_LATENCY must be 1 or 2");
    end
    if (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW) begin : g_bad_rdw
        $fatal(1, "RDW_MODE must be 0 or 1");
    end

    localparam int unsigned          IDX_W     = (WORD_DEPTH > 1) ? $clog2(WORD_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]  DEPTH_LIM = (ADDR_WIDTH + 1)'(WORD_DEPTH);

    logic [BITS-1:0] mem [WORD_DEPTH];

    logic             r0_in_range, rw0_in_range;
    logic [IDX_W-1:0] r0_idx, rw0_idx;
    logic             rw0_wr_en, rw0_rd_en, collision;
    logic [BITS-1:0]  merged_word, r0_word, rw0_word;
    logic             oob_err_q;
    logic [BITS:0]    r0_pipe_data;
    logic             r0_pipe_valid;

    assign r0_in_range  = {1'b0, r0_addr_in}  < DEPTH_LIM;
    assign rw0_in_range = {1'b0, rw0_addr_in} < DEPTH_LIM;
    assign r0_idx       = r0_addr_in[IDX_W-1:0];
    assign rw0_idx      = rw0_addr_in[IDX_W-1:0];

    assign rw0_wr_en = rw0_ce_in & rw0_we_in;
    assign rw0_rd_en = rw0_ce_in & ~rw0_we_in;
    assign collision = r0_ce_in & rw0_wr_en & r0_in_range & (r0_addr_in == rw0_addr_in);

    assign merged_word = BITS'(merge_word(SRAM_MAX_BITS'(mem[rw0_idx]), SRAM_MAX_BITS'(rw0_wd_in),
                                          SRAM_MAX_BITS'(rw0_wmask_in), MASK_GRAN));

    assign r0_word  = !r0_in_range ? '0 :
                      (collision && RDW_MODE == RDW_NEW) ? merged_word : mem[r0_idx];
    assign rw0_word = rw0_in_range ? mem[rw0_idx] : '0;

    // Array writes share the async-reset process so writes are suppressed while
    // rst_n is low; the reset branch deliberately leaves the contents untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oob_err_q <= 1'b0;
        end else begin
            if (rw0_wr_en && rw0_in_range) begin
                mem[rw0_idx] <= merged_word;
            end
            if ((r0_ce_in && !r0_in_range) || (rw0_ce_in && !rw0_in_range)) begin
                oob_err_q <= 1'b1;
            end
        end
    end

    // Collision flag rides alongside the r0 data as its top bit.
    liteeth_sram_rd_pipe #(
        .BITS         (BITS + 1),
        .READ_LATENCY (READ_LATENCY)
    ) u_r0_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (r0_ce_in),
        .data_in   ({collision, r0_word}),
        .valid_out (r0_pipe_valid),
        .data_out  (r0_pipe_data)
    );

    liteeth_sram_rd_pipe #(
        .BITS         (BITS),
        .READ_LATENCY (READ_LATENCY)
    ) u_rw0_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (rw0_rd_en),
        .data_in   (rw0_word),
        .valid_out (rw0_rd_valid_out),
        .data_out  (rw0_rd_out)
    );

    assign r0_rd_out       = r0_pipe_data[BITS-1:0];
    assign r0_rd_valid_out = r0_pipe_valid;
    assign collision_out   = r0_pipe_valid & r0_pipe_data[BITS];
    assign oob_err_out     = oob_err_q;

endmodule

// File: tb/tb_liteeth_1rw1r_sram_model.sv
// Directed bench: DUT 0 is READ_LATENCY=1/RDW_MODE=0, DUT 1 is READ_LATENCY=2/RDW_MODE=1.
module tb_liteeth_1rw1r_sram_model;

    logic        clk;
    logic        rst_n;
    logic        r0_ce      [2];
    logic [8:0]  r0_addr    [2];
    logic [31:0] r0_rd      [2];
    logic        r0_v       [2];
    logic        rw0_ce     [2];
    logic        rw0_we     [2];
    logic [8:0]  rw0_addr   [2];
    logic [31:0] rw0_wd     [2];
    logic [3:0]  rw0_wmask  [2];
    logic [31:0] rw0_rd     [2];
    logic        rw0_v      [2];
    logic        coll       [2];
    logic        oob        [2];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        liteeth_1rw1r_sram_model #(
            .BITS         (32),
            .WORD_DEPTH   (384),
            .ADDR_WIDTH   (9),
            .MASK_GRAN    (8),
            .READ_LATENCY (g + 1),
            .RDW_MODE     (g)
        ) u_dut (
            .clk              (clk),
            .rst_n            (rst_n),
            .r0_ce_in         (r0_ce[g]),
            .r0_addr_in       (r0_addr[g]),
            .r0_rd_out        (r0_rd[g]),
            .r0_rd_valid_out  (r0_v[g]),
            .rw0_ce_in        (rw0_ce[g]),
            .rw0_we_in        (rw0_we[g]),
            .rw0_addr_in      (rw0_addr[g]),
            .rw0_wd_in        (rw0_wd[g]),
            .rw0_wmask_in     (rw0_wmask[g]),
            .rw0_rd_out       (rw0_rd[g]),
            .rw0_rd_valid_out (rw0_v[g]),
            .collision_out    (coll[g]),
            .oob_err_out      (oob[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        r0c;
        logic [8:0]  r0a;
        logic        rwc;
        logic        rww;
        logic [8:0]  rwa;
        logic [31:0] wd;
        logic [3:0]  wm;
        logic [31:0] e_r0;
        logic        e_r0v;
        logic [31:0] e_rw;
        logic        e_rwv;
        logic        e_c;
        logic        e_oob;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] obs(input int d);
        return 128'({r0_rd[d], r0_v[d], rw0_rd[d], rw0_v[d], coll[d], oob[d]});
    endfunction

    task automatic set_in(input int d, input logic r0c, input logic [8:0] r0a,
                          input logic rwc, input logic rww, input logic [8:0] rwa,
                          input logic [31:0] wd, input logic [3:0] wm);
        r0_ce[d]     = r0c;
        r0_addr[d]   = r0a;
        rw0_ce[d]    = rwc;
        rw0_we[d]    = rww;
        rw0_addr[d]  = rwa;
        rw0_wd[d]    = wd;
        rw0_wmask[d] = wm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input int d, input logic r0c, input logic [8:0] r0a,
                       input logic rwc, input logic rww, input logic [8:0] rwa,
                       input logic [31:0] wd, input logic [3:0] wm);
        set_in(d, r0c, r0a, rwc, rww, rwa, wd, wm);
        tick();
    endtask

    logic [31:0] pipe_d [5];
    logic        pipe_v [5];

    initial begin
        //          r0c  r0a      rwc   rww   rwa      wd            wm     e_r0          e_r0v e_rw          e_rwv e_c   e_oob
        vecs[0]  = '{1'b0, 9'd0,   1'b1, 1'b1, 9'd5,   32'hDEADBEEF, 4'hF, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 9'd5,   1'b0, 1'b0, 9'd0,   32'h00000000, 4'h0, 32'hDEADBEEF, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 9'd0,   1'b0, 1'b0, 9'd0,   32'h00000000, 4'h0, 32'hDEADBEEF, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 9'd0,   1'b1, 1'b1, 9'd7,   32'h11223344, 4'hF, 32'hDEADBEEF, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 9'd0,   1'b1, 1'b1, 9'd7,   32'hAABBCCDD, 4'h5, 32'hDEADBEEF, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 9'd0,   1'b1, 1'b0, 9'd7,   32'h00000000, 4'h0, 32'hDEADBEEF, 1'b0, 32'h11BB33DD, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 9'd0,   1'b1, 1'b1, 9'd9,   32'h00000000, 4'hF, 32'hDEADBEEF, 1'b0, 32'h11BB33DD, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 9'd9,   1'b1, 1'b1, 9'd9,   32'h12345678, 4'hF, 32'h00000000, 1'b1, 32'h11BB33DD, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 9'd9,   1'b1, 1'b0, 9'd9,   32'h00000000, 4'h0, 32'h12345678, 1'b1, 32'h12345678, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 9'd9,   1'b1, 1'b1, 9'd9,   32'hFFFFFFFF, 4'h0, 32'h12345678, 1'b1, 32'h12345678, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 9'd9,   1'b0, 1'b0, 9'd0,   32'h00000000, 4'h0, 32'h12345678, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 9'd0,   1'b1, 1'b1, 9'd144, 32'hCAFEF00D, 4'hF, 32'h12345678, 1'b0, 32'h12345678, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 9'd0,   1'b1, 1'b1, 9'd400, 32'hFFFFFFFF, 4'hF, 32'h12345678, 1'b0, 32'h12345678, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 9'd400, 1'b0, 1'b0, 9'd0,   32'h00000000, 4'h0, 32'h00000000, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 9'd144, 1'b0, 1'b0, 9'd0,   32'h00000000, 4'h0, 32'hCAFEF00D, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 9'd0,   1'b1, 1'b0, 9'd400, 32'h00000000, 4'h0, 32'hCAFEF00D, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[16] = '{1'b1, 9'd144, 1'b1, 1'b1, 9'd144, 32'h5A000000, 4'h8, 32'hCAFEF00D, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b1};
        vecs[17] = '{1'b1, 9'd5,   1'b1, 1'b0, 9'd144, 32'h00000000, 4'h0, 32'hDEADBEEF, 1'b1, 32'h5AFEF00D, 1'b1, 1'b0, 1'b1};

        pipe_d = '{32'h00000000, 32'hA1A10001, 32'hB2B20002, 32'hC3C30003, 32'hC3C30003};
        pipe_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) set_in(d, 1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 32'h0, 4'h0);
        repeat (3) tick();
        check("reset_dut0", obs(0), 128'h0);
        check("reset_dut1", obs(1), 128'h0);
        rst_n = 1'b1;
        tick();

        // DUT 0: table-driven single-cycle-latency vectors
        for (int i = 0; i < 18; i++) begin
            cyc(0, vecs[i].r0c, vecs[i].r0a, vecs[i].rwc, vecs[i].rww, vecs[i].rwa, vecs[i].wd, vecs[i].wm);
            check($sformatf("vec%0d", i), obs(0),
                  128'({vecs[i].e_r0, vecs[i].e_r0v, vecs[i].e_rw, vecs[i].e_rwv, vecs[i].e_c, vecs[i].e_oob}));
        end
        set_in(0, 1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 32'h0, 4'h0);

        // DUT 1: preload words
        cyc(1, 1'b0, 9'd0, 1'b1, 1'b1, 9'd1, 32'hA1A10001, 4'hF);
        cyc(1, 1'b0, 9'd0, 1'b1, 1'b1, 9'd2, 32'hB2B20002, 4'hF);
        cyc(1, 1'b0, 9'd0, 1'b1, 1'b1, 9'd3, 32'hC3C30003, 4'hF);
        cyc(1, 1'b0, 9'd0, 1'b1, 1'b1, 9'd5, 32'hDEADBEEF, 4'hF);
        cyc(1, 1'b0, 9'd0, 1'b1, 1'b1, 9'd9, 32'h00000000, 4'hF);

        // Back-to-back reads at latency 2
        for (int k = 0; k < 5; k++) begin
            if (k < 3) cyc(1, 1'b1, 9'(k + 1), 1'b0, 1'b0, 9'd0, 32'h0, 4'h0);
            else       cyc(1, 1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 32'h0, 4'h0);
            check($sformatf("pipe%0d", k), 128'({r0_rd[1], r0_v[1]}), 128'({pipe_d[k], pipe_v[k]}));
        end

        // New-data collision, full and partial mask
        cyc(1, 1'b1, 9'd9, 1'b1, 1'b1, 9'd9, 32'h12345678, 4'hF);
        check("coll_new_lat1", 128'({r0_v[1], coll[1]}), 128'(2'b00));
        cyc(1, 1'b1, 9'd9, 1'b1, 1'b1, 9'd9, 32'hAABBCCDD, 4'h3);
        check("coll_new_full", 128'({r0_rd[1], r0_v[1], coll[1]}), 128'({32'h12345678, 1'b1, 1'b1}));
        cyc(1, 1'b1, 9'd9, 1'b0, 1'b0, 9'd0, 32'h0, 4'h0);
        check("coll_new_part", 128'({r0_rd[1], r0_v[1], coll[1]}), 128'({32'h1234CCDD, 1'b1, 1'b1}));
        cyc(1, 1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 32'h0, 4'h0);
        check("coll_after", 128'({r0_rd[1], r0_v[1], coll[1]}), 128'({32'h1234CCDD, 1'b1, 1'b0}));

        // Last in-range word vs first out-of-range address
        cyc(1, 1'b0, 9'd0, 1'b1, 1'b1, 9'd383, 32'h0BADCAFE, 4'hF);
        cyc(1, 1'b1, 9'd383, 1'b0, 1'b0, 9'd0, 32'h0, 4'h0);
        cyc(1, 1'b1, 9'd384, 1'b0, 1'b0, 9'd0, 32'h0, 4'h0);
        check("addr383", 128'({r0_rd[1], r0_v[1], oob[1]}), 128'({32'h0BADCAFE, 1'b1, 1'b1}));
        cyc(1, 1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 32'h0, 4'h0);
        check("addr384", 128'({r0_rd[1], r0_v[1], oob[1]}), 128'({32'h00000000, 1'b1, 1'b1}));

        // Reset with a read in flight; writes during reset must be dropped
        cyc(1, 1'b1, 9'd5, 1'b0, 1'b0, 9'd0, 32'h0, 4'h0);
        cyc(1, 1'b1, 9'd3, 1'b0, 1'b0, 9'd0, 32'h0, 4'h0);
        check("pre_reset", 128'({r0_rd[1], r0_v[1]}), 128'({32'hDEADBEEF, 1'b1}));
        set_in(1, 1'b1, 9'd3, 1'b1, 1'b1, 9'd5, 32'h00000000, 4'hF);
        rst_n = 1'b0;
        #1;
        check("rst_async_dut1", obs(1), 128'h0);
        check("rst_async_dut0", obs(0), 128'h0);
        repeat (2) tick();
        set_in(1, 1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 32'h0, 4'h0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("no_valid_after_rst%0d", k), 128'({r0_v[1], rw0_v[1], r0_v[0], rw0_v[0]}), 128'(4'b0000));
        end
        cyc(1, 1'b1, 9'd5, 1'b0, 1'b0, 9'd0, 32'h0, 4'h0);
        set_in(1, 1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 32'h0, 4'h0);
        cyc(0, 1'b1, 9'd5, 1'b0, 1'b0, 9'd0, 32'h0, 4'h0);
        check("retain_dut0", 128'({r0_rd[0], r0_v[0], oob[0]}), 128'({32'hDEADBEEF, 1'b1, 1'b0}));
        check("retain_dut1", 128'({r0_rd[1], r0_v[1], oob[1]}), 128'({32'hDEADBEEF, 1'b1, 1'b0}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
